// File: rtl/timer_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_reg_pkg
// Description : Shared constants and types for the timer register block:
//               per-channel register offsets, CTRL bit positions, counter
//               "done" encoding and the per-channel start FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_reg_pkg;

    // Register offsets inside one channel's 8-byte window
    localparam logic [2:0] c_off_ctrl      = 3'd0;
    localparam logic [2:0] c_off_int       = 3'd1;
    localparam logic [2:0] c_off_cnt_con   = 3'd2;
    localparam logic [2:0] c_off_load_addr = 3'd3;
    localparam logic [2:0] c_off_load_val  = 3'd4;
    localparam logic [2:0] c_off_count_val = 3'd5;
    localparam logic [2:0] c_off_state     = 3'd6;
    localparam logic [2:0] c_off_rsvd      = 3'd7;

    // CTRL write bit positions
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_ar    = 1;
    localparam int c_ctrl_ie    = 2;
    localparam int c_ctrl_stop  = 3;

    // Counter state value that, together with a zero count, marks completion
    localparam logic [1:0] c_cnt_done = 2'b10;

    // Per-channel start sequencer
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RELOAD = 2'd3
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_reg_ch.sv
`default_nettype none
// ============================================================================
// Module      : timer_reg_ch
// Description : One timer channel: CTRL (AR/IE), CNT_CON, LOAD_ADDRESS
//               registers, start/reload sequencer and interrupt pending
//               flag with write-1-to-clear.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_reg_ch
    import timer_reg_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_ctrl_we,
    input  logic          i_ctrl_ar,
    input  logic          i_ctrl_ie,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_int_clr,
    input  logic          i_cnt_con_we,
    input  logic          i_cnt_con_bit,
    input  logic          i_load_addr_we,
    input  logic [DW-1:0] i_load_addr,
    input  logic [2:0]    i_master_state,
    input  logic [1:0]    i_counter_state,
    input  logic [DW-1:0] i_count_value,
    output logic          o_read_req,
    output logic          o_int_clear,
    output logic          o_irq,
    output logic          o_pending,
    output logic          o_ar,
    output logic          o_ie,
    output logic          o_cnt_con,
    output logic [DW-1:0] o_load_addr
);

    ch_state_e     r_state_q, w_state_d;
    logic          r_ar_q, w_ar_d;
    logic          r_ie_q, w_ie_d;
    logic          r_cnt_con_q, w_cnt_con_d;
    logic [DW-1:0] r_load_addr_q, w_load_addr_d;
    logic          r_pending_q, w_pending_d;
    logic          r_int_clear_q, w_int_clear_d;
    logic          r_done_q, w_done_d;

    logic          w_idle;
    logic          w_done_evt;

    assign w_idle     = (i_master_state == 3'd0) && (i_counter_state == 2'd0);
    assign w_done_d   = (i_counter_state == c_cnt_done) && (i_count_value == '0);
    assign w_done_evt = w_done_d && !r_done_q;

    // Start sequencer next state; STOP overrides everything except IDLE
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (i_start && !i_stop && w_idle) w_state_d = ST_REQ;
            end
            ST_REQ: begin
                w_state_d = i_stop ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                if (i_stop)          w_state_d = ST_IDLE;
                else if (w_done_evt) w_state_d = r_ar_q ? ST_RELOAD : ST_IDLE;
            end
            ST_RELOAD: begin
                if (i_stop)      w_state_d = ST_IDLE;
                else if (w_idle) w_state_d = ST_REQ;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Register fields and interrupt pending; a new done event beats a clear
    always_comb begin
        w_ar_d        = r_ar_q;
        w_ie_d        = r_ie_q;
        w_cnt_con_d   = r_cnt_con_q;
        w_load_addr_d = r_load_addr_q;
        if (i_ctrl_we) begin
            w_ar_d = i_ctrl_ar;
            w_ie_d = i_ctrl_ie;
        end
        if (i_cnt_con_we)   w_cnt_con_d   = i_cnt_con_bit;
        if (i_load_addr_we) w_load_addr_d = i_load_addr;
        w_pending_d   = w_done_evt || (r_pending_q && !i_int_clr);
        w_int_clear_d = i_int_clr && r_pending_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q     <= ST_IDLE;
            r_ar_q        <= 1'b0;
            r_ie_q        <= 1'b0;
            r_cnt_con_q   <= 1'b0;
            r_load_addr_q <= '0;
            r_pending_q   <= 1'b0;
            r_int_clear_q <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ar_q        <= w_ar_d;
            r_ie_q        <= w_ie_d;
            r_cnt_con_q   <= w_cnt_con_d;
            r_load_addr_q <= w_load_addr_d;
            r_pending_q   <= w_pending_d;
            r_int_clear_q <= w_int_clear_d;
            r_done_q      <= w_done_d;
        end
    end

    assign o_read_req  = (r_state_q == ST_REQ);
    assign o_int_clear = r_int_clear_q;
    assign o_irq       = r_pending_q && r_ie_q;
    assign o_pending   = r_pending_q;
    assign o_ar        = r_ar_q;
    assign o_ie        = r_ie_q;
    assign o_cnt_con   = r_cnt_con_q;
    assign o_load_addr = r_load_addr_q;

endmodule
`default_nettype wire

// File: rtl/timer_reg_nch.sv
`default_nettype none
// ============================================================================
// Module      : timer_reg_nch
// Description : Bus-slave register block for NUM_CH timer channels. Decodes
//               the slave bus into per-channel windows plus one GLOBAL
//               register (IRQ summary / multi-channel start) and returns
//               registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_reg_nch
    import timer_reg_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          DW        = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 S_sel,
    input  logic [7:0]           S_address,
    input  logic                 S_wr,
    input  logic [DW-1:0]        S_din,
    input  logic [3*NUM_CH-1:0]  NEXT_master_state,
    input  logic [2*NUM_CH-1:0]  NEXT_counter_state,
    input  logic [DW*NUM_CH-1:0] NEXT_LOAD_VALUE,
    input  logic [DW*NUM_CH-1:0] NEXT_COUNT_VALUE,
    output logic [DW-1:0]        S_dout,
    output logic [NUM_CH-1:0]    read_req,
    output logic [DW*NUM_CH-1:0] LOAD_ADDRESS,
    output logic [NUM_CH-1:0]    CNT_CON,
    output logic [NUM_CH-1:0]    int_clear,
    output logic [NUM_CH-1:0]    irq_vec,
    output logic                 interrupt
);

    // Offset of the GLOBAL register relative to BASE_ADDR
    localparam logic [8:0] c_glob_rel = 9'(8 * NUM_CH);

    logic [8:0]        w_rel;
    logic              w_hit;
    logic              w_global;
    logic [4:0]        w_idx;
    logic [2:0]        w_off;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_ar;
    logic [NUM_CH-1:0] w_ie;
    logic [DW-1:0]     w_s_dout_d;
    logic [DW-1:0]     r_s_dout_q;

    // Addresses below BASE_ADDR borrow into bit 8 and fall outside the window
    assign w_rel    = {1'b0, S_address} - {1'b0, BASE_ADDR};
    assign w_hit    = S_sel && (w_rel <= c_glob_rel);
    assign w_global = w_hit && (w_rel == c_glob_rel);
    assign w_idx    = w_rel[7:3];
    assign w_off    = w_rel[2:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_wr;
        logic w_ctrl_we;
        logic w_start;

        assign w_wr      = w_hit && !w_global && S_wr && (w_idx == 5'(c));
        assign w_ctrl_we = w_wr && (w_off == c_off_ctrl);
        assign w_start   = (w_ctrl_we && S_din[c_ctrl_start])
                        || (w_global && S_wr && S_din[c]);

        timer_reg_ch #(
            .DW (DW)
        ) u_ch (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_ctrl_we       (w_ctrl_we),
            .i_ctrl_ar       (S_din[c_ctrl_ar]),
            .i_ctrl_ie       (S_din[c_ctrl_ie]),
            .i_start         (w_start),
            .i_stop          (w_ctrl_we && S_din[c_ctrl_stop]),
            .i_int_clr       (w_wr && (w_off == c_off_int) && S_din[0]),
            .i_cnt_con_we    (w_wr && (w_off == c_off_cnt_con)),
            .i_cnt_con_bit   (S_din[0]),
            .i_load_addr_we  (w_wr && (w_off == c_off_load_addr)),
            .i_load_addr     (S_din),
            .i_master_state  (NEXT_master_state[3*c +: 3]),
            .i_counter_state (NEXT_counter_state[2*c +: 2]),
            .i_count_value   (NEXT_COUNT_VALUE[DW*c +: DW]),
            .o_read_req      (read_req[c]),
            .o_int_clear     (int_clear[c]),
            .o_irq           (irq_vec[c]),
            .o_pending       (w_pending[c]),
            .o_ar            (w_ar[c]),
            .o_ie            (w_ie[c]),
            .o_cnt_con       (CNT_CON[c]),
            .o_load_addr     (LOAD_ADDRESS[DW*c +: DW])
        );
    end

    // Read mux: returns pre-update register values and live channel inputs
    always_comb begin
        w_s_dout_d = '0;
        if (w_hit && !S_wr) begin
            if (w_global) begin
                w_s_dout_d = DW'(irq_vec);
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_idx == 5'(c)) begin
                        case (w_off)
                            c_off_ctrl:      w_s_dout_d = DW'({w_ie[c], w_ar[c], 1'b0});
                            c_off_int:       w_s_dout_d = DW'(w_pending[c]);
                            c_off_cnt_con:   w_s_dout_d = DW'(CNT_CON[c]);
                            c_off_load_addr: w_s_dout_d = LOAD_ADDRESS[DW*c +: DW];
                            c_off_load_val:  w_s_dout_d = NEXT_LOAD_VALUE[DW*c +: DW];
                            c_off_count_val: w_s_dout_d = NEXT_COUNT_VALUE[DW*c +: DW];
                            c_off_state:     w_s_dout_d = DW'({NEXT_master_state[3*c +: 3],
                                                               NEXT_counter_state[2*c +: 2]});
                            c_off_rsvd:      w_s_dout_d = '0;
                            default:         w_s_dout_d = '0;
                        endcase
                    end
                end
            end
        end
    end

    // Registered read data; zero after any cycle that is not a mapped read
    always_ff @(posedge clk) begin
        if (!reset_n) r_s_dout_q <= '0;
        else          r_s_dout_q <= w_s_dout_d;
    end

    assign S_dout    = r_s_dout_q;
    assign interrupt = |irq_vec;

endmodule
`default_nettype wire
